// File: rtl/conv_lb_feeder.sv
// Ingress sequencer for the convolution line buffer: turns a framed pixel stream
// into push/pop/sof/eol commands while enforcing constant line width per frame.
package conv_pkg;
    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 16;
endpackage

module conv_lb_feeder #(
    parameter int PIXEL_W     = conv_pkg::PIXEL_W,
    parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
    parameter int CW          = $clog2(IMAGE_MAX_W+1)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en_i,
    input  logic               s_vld_i,
    output logic               s_rdy_o,
    input  logic [PIXEL_W-1:0] s_dat_i,
    input  logic               s_sof_i,
    input  logic               s_eol_i,
    output logic               lb_push_o,
    output logic               lb_pop_o,
    output logic [PIXEL_W-1:0] lb_dat_o,
    output logic               lb_sof_o,
    output logic               lb_eol_o,
    output logic [CW-1:0]      line_w_o,
    output logic [15:0]        row_o,
    output logic               err_vld_o,
    output logic [1:0]         err_code_o
);
    typedef enum logic [1:0] {IDLE, FIRST, LINES, ERR} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      line_w_d;
    logic [15:0]        row_d;
    logic               push_d, pop_d, sof_d, eol_d, err_d;
    logic [1:0]         code_d;
    logic [PIXEL_W-1:0] dat_d;
    logic               acc, new_frame, last;

    assign s_rdy_o = en_i;
    assign acc     = s_vld_i & en_i;

    // A sof is a legal frame start outside a frame or exactly on a line boundary.
    assign new_frame = s_sof_i & ((state_q == IDLE) | (state_q == ERR) |
                                  ((state_q == LINES) && (col_q == '0)));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        line_w_d = line_w_o;
        row_d    = row_o;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        sof_d    = 1'b0;
        eol_d    = 1'b0;
        err_d    = 1'b0;
        code_d   = err_code_o;
        dat_d    = lb_dat_o;
        last     = 1'b0;
        if (acc) begin
            if (new_frame) begin
                push_d = 1'b1;
                sof_d  = 1'b1;
                eol_d  = s_eol_i;
                dat_d  = s_dat_i;
                if (s_eol_i) begin
                    line_w_d = CW'(1);
                    row_d    = 16'd1;
                    col_d    = '0;
                    state_d  = LINES;
                end else begin
                    row_d   = 16'd0;
                    col_d   = CW'(1);
                    state_d = FIRST;
                end
            end else if (state_q == FIRST || state_q == LINES) begin
                push_d = 1'b1;
                pop_d  = (state_q == LINES);
                dat_d  = s_dat_i;
                eol_d  = s_eol_i;
                last   = (state_q == FIRST) ? (col_q == CW'(IMAGE_MAX_W-1))
                                            : (col_q == line_w_o - 1'b1);
                if (s_sof_i) begin
                    // Mid-line sof: close the line so the buffer's packing resyncs.
                    eol_d   = 1'b1;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = ERR;
                end else if (state_q == FIRST && s_eol_i) begin
                    line_w_d = CW'(col_q + 1'b1);
                    col_d    = '0;
                    row_d    = 16'd1;
                    state_d  = LINES;
                end else if (last && s_eol_i) begin
                    col_d = '0;
                    row_d = (row_o == 16'hFFFF) ? row_o : row_o + 16'd1;
                end else if (last) begin
                    eol_d   = 1'b1;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = ERR;
                end else if (s_eol_i) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = ERR;
                end else begin
                    col_d = CW'(col_q + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            line_w_o   <= '0;
            row_o      <= '0;
            lb_push_o  <= 1'b0;
            lb_pop_o   <= 1'b0;
            lb_sof_o   <= 1'b0;
            lb_eol_o   <= 1'b0;
            lb_dat_o   <= '0;
            err_vld_o  <= 1'b0;
            err_code_o <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_w_o   <= line_w_d;
            row_o      <= row_d;
            lb_push_o  <= push_d;
            lb_pop_o   <= pop_d;
            lb_sof_o   <= sof_d;
            lb_eol_o   <= eol_d;
            lb_dat_o   <= dat_d;
            err_vld_o  <= err_d;
            err_code_o <= code_d;
        end
    end
endmodule
